// File: rtl/i2c_pkg.sv
// i2c_pkg: shared I2C state encoding, bus-event bundle and helpers.
// Used by i2c_target and i2c_bus_cond; the master refactor will reuse it.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX,
    RX_ACK,
    RX_NACK,
    TX,
    TX_ACK,
    WAIT_STOP
  } state_t;

  localparam int RNW_BIT = 0;

  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic start;
    logic stop;
    logic sda;
  } bus_ev_t;

  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/i2c_target_if.sv
// i2c_target_if: open-drain I2C pins between bus side and target.
// SDA_IN carries the resolved wired-AND line level.
interface i2c_target_if;
  logic SCL;
  logic SDA_IN;
  logic SDA_OUT;
  logic SDA_OE;

  modport master (
    output SCL,
    output SDA_IN,
    input  SDA_OUT,
    input  SDA_OE
  );

  modport slave (
    input  SCL,
    input  SDA_IN,
    output SDA_OUT,
    output SDA_OE
  );
endinterface

// File: rtl/i2c_bus_cond.sv
// i2c_bus_cond: SCL/SDA sync, optional majority filter, edge/START/STOP.
// Define I2C_TARGET_GLITCH_FILTER_EN to add the 3-sample majority filter.
module i2c_bus_cond
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic    CLK,
  input  logic    RESET,
  input  logic    scl,
  input  logic    sda,
  output bus_ev_t ev
);

  localparam int WARM = SYNC_STAGES + 4;
  localparam int WW = $clog2(WARM + 1);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic scl_s;
  logic sda_s;
  logic scl_f;
  logic sda_f;
  logic scl_p;
  logic sda_p;
  logic [WW-1:0] warm;
  logic armed;

  assign scl_s = scl_sync[SYNC_STAGES-1];
  assign sda_s = sda_sync[SYNC_STAGES-1];
  assign armed = (warm == WW'(WARM));

  // synchronizer chains, reset to the idle-high bus level
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] scl_h;
  logic [1:0] sda_h;

  // majority of three samples drops single-cycle pulses
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      scl_h <= '1;
      sda_h <= '1;
      scl_f <= 1'b1;
      sda_f <= 1'b1;
    end else begin
      scl_h <= {scl_h[0], scl_s};
      sda_h <= {sda_h[0], sda_s};
      scl_f <= maj3(scl_s, scl_h[0], scl_h[1]);
      sda_f <= maj3(sda_s, sda_h[0], sda_h[1]);
    end
  end
`else
  assign scl_f = scl_s;
  assign sda_f = sda_s;
`endif

  // events are masked until the chains hold real pin values after reset
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      scl_p       <= 1'b1;
      sda_p       <= 1'b1;
      warm        <= '0;
      ev.scl_rise <= 1'b0;
      ev.scl_fall <= 1'b0;
      ev.start    <= 1'b0;
      ev.stop     <= 1'b0;
      ev.sda      <= 1'b1;
    end else begin
      scl_p <= scl_f;
      sda_p <= sda_f;
      if (!armed) warm <= warm + WW'(1);
      ev.scl_rise <= armed & scl_f & ~scl_p;
      ev.scl_fall <= armed & ~scl_f & scl_p;
      ev.start    <= armed & scl_f & scl_p & sda_p & ~sda_f;
      ev.stop     <= armed & scl_f & scl_p & ~sda_p & sda_f;
      ev.sda      <= sda_f;
    end
  end

endmodule

// File: rtl/i2c_target.sv
// i2c_target: 7-bit address I2C responder, two-byte write/read payloads.
// I2C_TARGET_GLITCH_FILTER_EN enables the input majority filter.
module i2c_target
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_BYTES   = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [6:0]  I2C_ADDR,
  i2c_target_if.slave bus,
  input  logic [15:0] RD_DATA,
  output logic [15:0] WR_DATA,
  output logic        WR_VALID,
  output logic        TWOBYTE_RX,
  output logic        BUSY
);

  localparam int IW = $clog2(MAX_BYTES + 1);
  localparam logic [IW-1:0] MAXB = IW'(MAX_BYTES);

  bus_ev_t ev;

  state_t state, state_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [6:0]    shreg, sh_n;
  logic          rnw, rnw_n;
  logic [15:0]   rd_buf, rdb_n;
  logic [IW-1:0] byte_idx, idx_n;
  logic          tx_sel, sel_n;
  logic          ack_ph, ph_n;
  logic          oe, oe_n;
  logic [15:0]   wd_n;
  logic          wv_n;
  logic          two_n;
  logic          busy_n;

  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic [7:0] nxt_byte;
  logic       wrote;

  i2c_bus_cond #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_cond (
    .CLK  (CLK),
    .RESET(RESET),
    .scl  (bus.SCL),
    .sda  (bus.SDA_IN),
    .ev   (ev)
  );

  assign rx_byte  = {shreg, ev.sda};
  assign tx_byte  = tx_sel ? rd_buf[7:0] : rd_buf[15:8];
  assign nxt_byte = tx_sel ? rd_buf[15:8] : rd_buf[7:0];
  assign wrote    = busy_q() & ~rnw & (byte_idx != '0);

  function automatic logic busy_q();
    return BUSY;
  endfunction

  assign bus.SDA_OE  = oe;
  assign bus.SDA_OUT = ~oe;

  // next-state and datapath decode; START/STOP override bit activity
  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    rnw_n   = rnw;
    rdb_n   = rd_buf;
    idx_n   = byte_idx;
    sel_n   = tx_sel;
    ph_n    = ack_ph;
    oe_n    = oe;
    wd_n    = WR_DATA;
    wv_n    = 1'b0;
    two_n   = TWOBYTE_RX;
    busy_n  = BUSY;
    if (ev.start || ev.stop) begin
      state_n = ev.start ? ADDR : IDLE;
      bit_n   = '0;
      ph_n    = 1'b0;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
      idx_n   = '0;
      wv_n    = wrote;
      if (wrote) two_n = (byte_idx > IW'(1));
    end else begin
      unique case (state)
        IDLE, WAIT_STOP: begin
        end
        ADDR: begin
          if (ev.scl_rise) begin
            sh_n  = rx_byte[6:0];
            bit_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (rx_byte[7:1] == I2C_ADDR) begin
                state_n = ADDR_ACK;
                rnw_n   = rx_byte[RNW_BIT];
                busy_n  = 1'b1;
                idx_n   = '0;
                sel_n   = 1'b0;
                ph_n    = 1'b0;
                if (rx_byte[RNW_BIT]) rdb_n = RD_DATA;
              end else begin
                state_n = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (ev.scl_fall) begin
            if (!ack_ph) begin
              oe_n = 1'b1;
              ph_n = 1'b1;
            end else begin
              ph_n  = 1'b0;
              bit_n = '0;
              if (rnw) begin
                state_n = TX;
                oe_n    = ~tx_byte[7];
              end else begin
                state_n = RX;
                oe_n    = 1'b0;
              end
            end
          end
        end
        RX: begin
          if (ev.scl_rise) begin
            sh_n  = rx_byte[6:0];
            bit_n = bit_cnt + 3'd1;
            ph_n  = 1'b0;
            if (bit_cnt == 3'd7) begin
              if (byte_idx < MAXB) begin
                if (byte_idx == '0) wd_n[15:8] = rx_byte;
                else wd_n[7:0] = rx_byte;
                idx_n   = byte_idx + IW'(1);
                state_n = RX_ACK;
              end else begin
                state_n = RX_NACK;
              end
            end
          end
        end
        RX_ACK, RX_NACK: begin
          if (ev.scl_fall) begin
            if (!ack_ph) begin
              oe_n = (state == RX_ACK);
              ph_n = 1'b1;
            end else begin
              oe_n    = 1'b0;
              ph_n    = 1'b0;
              state_n = (state == RX_ACK) ? RX : WAIT_STOP;
            end
          end
        end
        TX: begin
          if (ev.scl_fall) begin
            if (bit_cnt == 3'd7) begin
              oe_n    = 1'b0;
              bit_n   = '0;
              ph_n    = 1'b0;
              state_n = TX_ACK;
            end else begin
              bit_n = bit_cnt + 3'd1;
              oe_n  = ~tx_byte[3'd6 - bit_cnt];
            end
          end
        end
        TX_ACK: begin
          if (ev.scl_rise) begin
            if (ev.sda) state_n = WAIT_STOP;
            else ph_n = 1'b1;
          end else if (ev.scl_fall && ack_ph) begin
            ph_n    = 1'b0;
            sel_n   = ~tx_sel;
            bit_n   = '0;
            oe_n    = ~nxt_byte[7];
            state_n = TX;
          end
        end
        default: begin
          state_n = IDLE;
          oe_n    = 1'b0;
        end
      endcase
    end
  end

  // state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else state <= state_n;
  end

  // datapath and output registers; reset releases SDA at once
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      bit_cnt    <= '0;
      shreg      <= '0;
      rnw        <= 1'b0;
      rd_buf     <= '0;
      byte_idx   <= '0;
      tx_sel     <= 1'b0;
      ack_ph     <= 1'b0;
      oe         <= 1'b0;
      WR_DATA    <= '0;
      WR_VALID   <= 1'b0;
      TWOBYTE_RX <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      bit_cnt    <= bit_n;
      shreg      <= sh_n;
      rnw        <= rnw_n;
      rd_buf     <= rdb_n;
      byte_idx   <= idx_n;
      tx_sel     <= sel_n;
      ack_ph     <= ph_n;
      oe         <= oe_n;
      WR_DATA    <= wd_n;
      WR_VALID   <= wv_n;
      TWOBYTE_RX <= two_n;
      BUSY       <= busy_n;
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: behavioural I2C master plus transaction-level model.
// Directed scenarios followed by randomized write/read transfers.
module tb_i2c_target;

  localparam int Q = 80;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [6:0]  I2C_ADDR = 7'h29;
  logic [15:0] RD_DATA = '0;
  logic [15:0] WR_DATA;
  logic        WR_VALID;
  logic        TWOBYTE_RX;
  logic        BUSY;

  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_bus;

  i2c_target_if bus ();

  assign sda_bus = sda_m & (bus.SDA_OE ? bus.SDA_OUT : 1'b1);
  assign bus.SCL = scl;
  assign bus.SDA_IN = sda_bus;

  i2c_target dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .I2C_ADDR  (I2C_ADDR),
    .bus       (bus),
    .RD_DATA   (RD_DATA),
    .WR_DATA   (WR_DATA),
    .WR_VALID  (WR_VALID),
    .TWOBYTE_RX(TWOBYTE_RX),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          wv_cnt = 0;
  int          wv_base = 0;
  logic [15:0] wv_data = '0;
  logic        wv_two = 1'b0;
  logic        oe_seen = 1'b0;
  logic        prev_oe = 1'b0;
  int          oe_hi_viol = 0;
  int          od_viol = 0;

  always @(negedge CLK) begin
    if (WR_VALID === 1'b1) begin
      wv_cnt++;
      wv_data = WR_DATA;
      wv_two = TWOBYTE_RX;
    end
    if (bus.SDA_OE === 1'b1) oe_seen = 1'b1;
    if (bus.SDA_OE === 1'b1 && bus.SDA_OUT !== 1'b0) od_viol++;
    if (scl && RESET && bus.SDA_OE !== prev_oe) oe_hi_viol++;
    prev_oe = bus.SDA_OE;
  end

  logic [15:0] exp_wr = '0;
  logic        pend_wv = 1'b0;
  logic        pend_two = 1'b0;

  task automatic bus_start();
    sda_m = 1'b1;
    scl = 1'b1;
    #Q;
    sda_m = 1'b0;
    #Q;
    scl = 1'b0;
    #Q;
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1;
    #Q;
    scl = 1'b1;
    #Q;
    sda_m = 1'b0;
    #Q;
    scl = 1'b0;
    #Q;
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    #Q;
    scl = 1'b1;
    #Q;
    sda_m = 1'b1;
    #(2 * Q);
  endtask

  task automatic clk_bit(input logic d, output logic s, output logic oe);
    sda_m = d;
    #Q;
    scl = 1'b1;
    #Q;
    s = sda_bus;
    oe = bus.SDA_OE;
    #Q;
    scl = 1'b0;
    #Q;
  endtask

  task automatic wr_byte(input logic [7:0] b, output logic ack, output logic oe9);
    logic s, o;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s, o);
    clk_bit(1'b1, s, oe9);
    ack = ~s;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] b);
    logic s, o;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s, o);
      b[i] = s;
    end
    clk_bit(nack, s, o);
  endtask

  task automatic do_write(input logic [6:0] a, input int n, input logic [31:0] data);
    logic ack, o9, match, e;
    logic [7:0] b;
    match = (a == I2C_ADDR);
    wr_byte({a, 1'b0}, ack, o9);
    chk("addr_ack", 32'(ack), 32'(match));
    for (int k = 0; k < n; k++) begin
      b = data[31 - 8 * k -: 8];
      wr_byte(b, ack, o9);
      e = match && (k < 2);
      chk("wr_ack", 32'(ack), 32'(e));
      chk("wr_oe9", 32'(o9), 32'(e));
      if (e) begin
        if (k == 0) exp_wr[15:8] = b;
        else exp_wr[7:0] = b;
      end
    end
    pend_wv = match && (n > 0);
    pend_two = match && (n >= 2);
  endtask

  task automatic do_read(input logic [6:0] a, input int n, input logic [15:0] rd);
    logic ack, o9;
    logic [7:0] b, e;
    RD_DATA = rd;
    wr_byte({a, 1'b1}, ack, o9);
    chk("rd_addr_ack", 32'(ack), 32'(a == I2C_ADDR));
    for (int k = 0; k < n; k++) begin
      rd_byte(k == n - 1, b);
      e = (k % 2 == 0) ? rd[15:8] : rd[7:0];
      chk("rd_byte", 32'(b), 32'(e));
    end
    pend_wv = 1'b0;
    pend_two = 1'b0;
  endtask

  task automatic end_check(input string tag);
    chk({tag, "_wv_count"}, 32'(wv_cnt - wv_base), 32'(pend_wv));
    if (pend_wv) begin
      chk({tag, "_wv_data"}, 32'(wv_data), 32'(exp_wr));
      chk({tag, "_wv_two"}, 32'(wv_two), 32'(pend_two));
    end
    chk({tag, "_wr_data"}, 32'(WR_DATA), 32'(exp_wr));
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic s, o, ack, o9;
    logic [7:0] b;
    #10;
    RESET = 1'b0;
    #30;
    chk("rst_oe", 32'(bus.SDA_OE), 32'h0);
    chk("rst_out", 32'(bus.SDA_OUT), 32'h1);
    chk("rst_wr_data", 32'(WR_DATA), 32'h0);
    chk("rst_wv", 32'(WR_VALID), 32'h0);
    chk("rst_two", 32'(TWOBYTE_RX), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    #10;
    RESET = 1'b1;
    #200;

    // write two bytes
    I2C_ADDR = 7'h29;
    wv_base = wv_cnt;
    bus_start();
    do_write(7'h29, 2, 32'hA53C_0000);
    chk("wr2_busy", 32'(BUSY), 32'h1);
    bus_stop();
    end_check("wr2");
    chk("wr2_busy_end", 32'(BUSY), 32'h0);

    // address mismatch
    wv_base = wv_cnt;
    oe_seen = 1'b0;
    bus_start();
    do_write(7'h2A, 1, 32'h1100_0000);
    chk("mis_busy", 32'(BUSY), 32'h0);
    bus_stop();
    chk("mis_oe_seen", 32'(oe_seen), 32'h0);
    end_check("mis");

    // read two bytes, NACK the second
    wv_base = wv_cnt;
    bus_start();
    do_read(7'h29, 2, 16'hBEEF);
    oe_seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      clk_bit(1'b1, s, o);
      chk("rd_idle_sda", 32'(s), 32'h1);
    end
    chk("rd_wait_oe", 32'(oe_seen), 32'h0);
    chk("rd_wait_busy", 32'(BUSY), 32'h1);
    bus_stop();
    end_check("rd2");

    // write overflow
    wv_base = wv_cnt;
    bus_start();
    do_write(7'h29, 3, 32'h0102_0300);
    bus_stop();
    end_check("ovf");

    // repeated START into a read
    wv_base = wv_cnt;
    bus_start();
    do_write(7'h29, 1, 32'h7700_0000);
    bus_rstart();
    end_check("sr");
    wv_base = wv_cnt;
    do_read(7'h29, 1, 16'h1234);
    bus_stop();
    end_check("sr_rd");

    // reset while the target drives a 0 bit
    bus_start();
    RD_DATA = 16'h0F00;
    wr_byte({7'h29, 1'b1}, ack, o9);
    chk("rtx_ack", 32'(ack), 32'h1);
    chk("rtx_drive", 32'(bus.SDA_OE), 32'h1);
    RESET = 1'b0;
    #1;
    chk("rtx_oe_async", 32'(bus.SDA_OE), 32'h0);
    exp_wr = '0;
    #29;
    RESET = 1'b1;
    oe_seen = 1'b0;
    wv_base = wv_cnt;
    for (int i = 0; i < 7; i++) clk_bit(1'b1, s, o);
    wr_byte(8'h52, ack, o9);
    chk("rtx_ignore_ack", 32'(ack), 32'h0);
    chk("rtx_oe_seen", 32'(oe_seen), 32'h0);
    chk("rtx_busy", 32'(BUSY), 32'h0);
    bus_stop();
    pend_wv = 1'b0;
    end_check("rtx");
    wv_base = wv_cnt;
    bus_start();
    do_write(7'h29, 2, 32'h5AC3_0000);
    bus_stop();
    end_check("rtx_after");

    // randomized transfers
    for (int it = 0; it < 24; it++) begin
      logic [6:0] own, a;
      logic match;
      own = 7'($urandom_range(8, 119));
      I2C_ADDR = own;
      match = ($urandom_range(0, 3) != 0);
      a = match ? own : own ^ 7'($urandom_range(1, 127));
      wv_base = wv_cnt;
      #(2 * Q);
      bus_start();
      if (match && $urandom_range(0, 1) == 1)
        do_read(a, $urandom_range(1, 3), 16'($urandom));
      else
        do_write(a, $urandom_range(0, 3), $urandom);
      bus_stop();
      end_check("rnd");
      chk("rnd_busy", 32'(BUSY), 32'h0);
    end

    chk("oe_change_scl_high", 32'(oe_hi_viol), 32'h0);
    chk("open_drain", 32'(od_viol), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C responder (target) for the bus driven by the team's I2C master; one 7-bit target address, up to two data bytes per transfer.
- Oversamples SCL/SDA on the system clock, detects START/STOP, decodes address+RNW, ACKs, then receives a write payload (HI then LO) or transmits a read payload.
- Sits on the device side of the bus; the bench pairs it with the master over a shared wired-AND SDA.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA_IN (minimum 2).
- MAX_BYTES, 2, data bytes accepted per write; the byte after the last is NACKed.

Ports:
- CLK  input  1  system clock, much faster than SCL (at least 8x).
- RESET  input  1  asynchronous, active-low reset.
- I2C_ADDR  input  7  own address; static while not idle.
- SCL  input  1  bus clock from the master.
- SDA_IN  input  1  resolved bus SDA.
- SDA_OUT  output  1  value driven when SDA_OE=1; always 0 when driving (open drain).
- SDA_OE  output  1  1 means the target pulls SDA low.
- RD_DATA  input  16  read payload; sampled at address ACK; [15:8] sent first.
- WR_DATA  output  16  last write payload; HI byte received into [15:8], LO byte into [7:0].
- WR_VALID  output  1  one-cycle pulse at STOP/repeated-START after at least 1 write byte.
- TWOBYTE_RX  output  1  valid with WR_VALID; 1 if two bytes were received.
- BUSY  output  1  high from our address match until STOP/START.

Behaviour:
- Reset values: SDA_OUT=1, SDA_OE=0, WR_DATA=0, WR_VALID=0, TWOBYTE_RX=0, BUSY=0, state=IDLE, bit counter=0. Reset mid-transfer releases SDA immediately.
- Input conditioning:
  - SCL and SDA_IN pass through SYNC_STAGES flops.
  - Edges are detected against a registered previous value.
  - Latency from pin edge to detected event is SYNC_STAGES+1 cycles.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both are detected in every state and have priority over bit activity.
  - START goes to ADDR from any state (repeated START); STOP goes to IDLE.
- Timing rules:
  - Sample SDA on the detected SCL rising edge.
  - Change SDA_OE only on the detected SCL falling edge, never while SCL is high.
- States:
  - IDLE: SDA released; waits for START.
  - ADDR: shift 8 bits MSB first. After the 8th rising edge, compare [7:1] with I2C_ADDR.
    - Match: go to ADDR_ACK and latch RNW; on RNW=1 also capture RD_DATA.
    - Mismatch: go to WAIT_STOP.
  - ADDR_ACK: drive SDA low from the falling edge after bit 8 to the next falling edge (the 9th clock). Then go to RX (RNW=0) or TX (RNW=1).
  - RX: shift 8 bits into a byte buffer. On the 8th rising edge:
    - If byte index < MAX_BYTES: store the byte (index 0 into WR_DATA[15:8], index 1 into [7:0]) and go to RX_ACK.
    - Otherwise: go to RX_NACK, which releases SDA for the 9th clock and then goes to WAIT_STOP.
  - RX_ACK: drive low for the 9th clock, increment the byte index, return to RX.
  - TX: on each falling edge, OE = NOT(current bit), so a 0 bit pulls low and a 1 bit releases SDA.
    - Byte 0 is RD_DATA[15:8]; byte 1 is [7:0]; byte 2 and later wrap to byte 0.
    - After the 8th bit, release SDA and go to TX_ACK.
  - TX_ACK: sample master ACK on the 9th rising edge. SDA=0 returns to TX with the next byte; SDA=1 (NACK) goes to WAIT_STOP.
  - WAIT_STOP: SDA released; only START or STOP leave this state.
- WR_DATA updates per byte as received. WR_VALID/TWOBYTE_RX fire only if the transfer was a matched write with at least 1 byte.
- Arbitration: none. The target never drives high, and SDA_OUT stays 0 whenever SDA_OE=1.
- Bit counter is 3 bits and wraps 7 to 0 at each byte boundary.

Optional Feature:
- I2C_TARGET_GLITCH_FILTER_EN defined: a 3-sample majority filter follows the synchronizers on SCL and SDA. Pulses of 1 CLK are rejected, and detection latency becomes SYNC_STAGES+3.
- Not defined: raw synchronized signals are used, with latency SYNC_STAGES+1.

Decomposition:
- Package i2c_pkg: state encoding constants (IDLE, ADDR, ADDR_ACK, RX, RX_ACK, RX_NACK, TX, TX_ACK, WAIT_STOP) and RNW bit position; shared with the master's future refactor.
- Sub-module i2c_bus_cond: synchronizer, optional filter, SCL rise/fall, START/STOP detection. The FSM stays in i2c_target.

Test Plan:
- Write 2 bytes: I2C_ADDR=7'h29, master sends 0x52, 0xA5, 0x3C, STOP. Three ACKs; WR_DATA=16'hA53C; WR_VALID pulses once; TWOBYTE_RX=1.
- Address mismatch: master sends 0x54 (addr 7'h2A), then byte 0x11. SDA_OE stays 0 throughout; no WR_VALID; BUSY=0.
- Read 2 bytes: RD_DATA=16'hBEEF, master sends 0x53, ACKs the first byte and NACKs the second. Target drives bits of 0xBE then 0xEF, then releases SDA; state reaches WAIT_STOP.
- Write overflow: three bytes 0x01, 0x02, 0x03. First two ACKed, third NACKed (SDA_OE=0 on 9th clock). WR_DATA=16'h0102 at STOP.
- Repeated START: write 0x52, 0x77, then Sr plus 0x53 read with RD_DATA=16'h1234. WR_VALID pulses at Sr with WR_DATA[15:8]=0x77, TWOBYTE_RX=0; target then transmits 0x12.
- Reset mid-TX: assert RESET while the target drives a 0 bit. SDA_OE goes to 0 asynchronously; after release the target ignores the bus until the next START.
